cc_frame_tx: RTL
================

Name: cc_frame_tx

Overview:
Parametrised serial frame transmitter, the successor to the fixed 8N1 byte sender on the CC path. It reads FRAME_LEN words from an external synchronous RAM, starting at a runtime start address, and shifts them out on tx in UART-style framing. Bit period, data width, bit order, stop-bit count and frame length are all configurable. Adds busy/done status, abort, and a progress counter.

Parameters:
- DATA_BITS, 8: data bits per word, 5..9.
- ADDR_W, 12: RAM address width.
- FRAME_LEN, 48: words per frame, 1..2^ADDR_W.
- BIT_CYCLES, 49: clock cycles per bit, ≥2.
- STOP_BITS, 1: stop bits, 1 or 2.
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = MSB sent first.
- PARITY_ODD, 0: parity sense, used only with CC_TX_PARITY_EN (0 = even, 1 = odd).

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- RDY, input, 1: level start request, sampled in IDLE.
- start_addr, input, ADDR_W: first RAM address, latched on start.
- abort, input, 1: synchronous cancel.
- rdaddress, output, ADDR_W: RAM read address.
- data, input, DATA_BITS: RAM read data, valid 1 cycle after rdaddress.
- tx, output, 1: serial line, idle high.
- busy, output, 1: high from start to end of frame.
- done, output, 1: one-cycle pulse when a frame completes normally.
- words_sent, output, ADDR_W+1: count of words fully transmitted in the current frame.

Behaviour:
- Reset (async, immediate):
  - tx=1, busy=0, done=0, rdaddress=0, words_sent=0.
  - Bit counter, divider and shift buffer cleared; state=IDLE.
- All outputs are registered.
- States: IDLE, FETCH, START, DATA, PARITY (macro only), STOP, DONE.
- IDLE:
  - tx=1, busy=0.
  - If RDY=1: rdaddress<=start_addr, words_sent<=0, busy<=1, go to FETCH.
- FETCH: exactly 1 cycle. At its end:
  - BUFF<=data; rdaddress<=rdaddress+1 (wraps modulo 2^ADDR_W).
  - tx<=0; go to START.
- START: tx=0 for BIT_CYCLES cycles, then DATA.
- DATA: DATA_BITS bits, each held BIT_CYCLES cycles.
  - Order is set by LSB_FIRST.
  - After the last bit, go to PARITY if enabled, else STOP.
- STOP:
  - tx=1 for STOP_BITS*BIT_CYCLES cycles.
  - On the last cycle, words_sent increments.
  - If words_sent (new value) == FRAME_LEN, go to DONE; else go to FETCH.
- Inter-word idle-high time is STOP_BITS*BIT_CYCLES+1 cycles, because the FETCH cycle holds tx=1.
- DONE: 1 cycle with done=1, busy=0, tx=1, then IDLE.
  - If RDY is still high, a new frame starts from IDLE on the following cycle; RDY is level-sensitive with no edge detect.
- Divider:
  - Counts 0..BIT_CYCLES-1 and restarts on every tx transition.
  - Every bit is exactly BIT_CYCLES cycles, with no off-by-one.
- Abort: abort=1 in any non-IDLE state means next cycle is IDLE with tx=1, busy=0, no done pulse, and words_sent holding its value. abort has priority over all other transitions.
- RDY changes during a frame are ignored. start_addr is sampled only in IDLE.
- FRAME_LEN=1: a single word, then DONE.
- Total frame time: FRAME_LEN*(1+BIT_CYCLES*(1+DATA_BITS+P+STOP_BITS)) cycles from the IDLE exit to the done pulse, where P=1 with parity and 0 without.

Optional Feature:
- Macro CC_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted after DATA, for one bit of BIT_CYCLES cycles.
  - tx = XOR of the data bits XOR PARITY_ODD.
- Undefined:
  - No PARITY state and no parity logic; DATA goes directly to STOP.
  - PARITY_ODD is ignored.

Test Plan:
- Byte shape, parity off (BIT_CYCLES=4, DATA_BITS=8, STOP_BITS=1, FRAME_LEN=1, LSB_FIRST=1), RAM[0]=0xA5, start_addr=0, RDY pulse:
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
  - done pulses 41 cycles after the IDLE exit; words_sent=1.
- Frame, address wrap, MSB-first (ADDR_W=4, FRAME_LEN=3, start_addr=0xE, LSB_FIRST=0):
  - rdaddress sequence is E, F, 0.
  - Bits of each word are sent MSB first.
  - Exactly 3 words are sent, then one done pulse.
- Parity (CC_TX_PARITY_EN, PARITY_ODD=0, data 0x07):
  - Parity bit = 1.
  - With PARITY_ODD=1 the parity bit = 0.
  - Word length = 11*BIT_CYCLES+1 cycles.
- Abort mid-DATA on word 2 of 4:
  - tx=1 and busy=0 on the next cycle; no done pulse; words_sent=1.
  - A new RDY restarts from start_addr.
- RDY held high continuously (FRAME_LEN=2):
  - Back-to-back frames with exactly 1 DONE cycle plus 1 IDLE cycle between them.
  - done pulses once per frame.
- Async reset asserted during STOP with STOP_BITS=2:
  - tx=1, busy=0, rdaddress=0 immediately, with no clock edge needed.
  - No activity after release until RDY goes high.

Source files
------------

// File: rtl/cc_frame_tx.sv
// cc_frame_tx: reads FRAME_LEN words from a synchronous RAM and sends them as UART-style frames.
// Define CC_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module cc_frame_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned FRAME_LEN  = 48,
    parameter int unsigned BIT_CYCLES = 49,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned LSB_FIRST  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 RDY,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic                 abort,
    output logic [ADDR_W-1:0]    rdaddress,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      words_sent
);

    localparam int unsigned StopCycles = STOP_BITS * BIT_CYCLES;
    localparam int unsigned DivW       = $clog2(StopCycles + 1);
    localparam int unsigned BitW       = $clog2(DATA_BITS + 1);

    localparam logic [DivW-1:0]   BitLast  = DivW'(BIT_CYCLES - 1);
    localparam logic [DivW-1:0]   StopLast = DivW'(StopCycles - 1);
    localparam logic [BitW-1:0]   DataLast = BitW'(DATA_BITS - 1);
    localparam logic [ADDR_W:0]   FrameEnd = (ADDR_W + 1)'(FRAME_LEN);

    if (DATA_BITS < 5 || DATA_BITS > 9 || BIT_CYCLES < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FRAME_LEN < 1 || FRAME_LEN > (1 << ADDR_W) || LSB_FIRST > 1 || PARITY_ODD > 1)
    begin : g_bad_cfg
        $error("cc_frame_tx: illegal parameter set");
    end

`ifdef CC_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StParity, StStop, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StStop, StDone} state_e;
`endif

    state_e               r_state;
    logic [DivW-1:0]      r_div;
    logic [BitW-1:0]      r_bit;
    logic [DATA_BITS-1:0] r_buff;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W:0]      r_words;
`ifdef CC_TX_PARITY_EN
    logic                 r_par;
`endif

    logic                 w_out_bit;
    logic [DATA_BITS-1:0] w_shifted;
    logic [ADDR_W:0]      w_words_next;

    // The next bit to send always sits at the head of r_buff; shift direction follows bit order.
    assign w_out_bit    = (LSB_FIRST != 0) ? r_buff[0] : r_buff[DATA_BITS-1];
    assign w_shifted    = (LSB_FIRST != 0) ? (r_buff >> 1) : (r_buff << 1);
    assign w_words_next = r_words + (ADDR_W + 1)'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_buff  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_words <= '0;
`ifdef CC_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (abort && r_state != StIdle) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                    if (RDY) begin
                        r_addr  <= start_addr;
                        r_words <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StFetch;
                    end
                end
                StFetch: begin
                    r_buff  <= data;
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_tx    <= 1'b0;
                    r_div   <= '0;
                    r_state <= StStart;
`ifdef CC_TX_PARITY_EN
                    r_par   <= (^data) ^ 1'(PARITY_ODD);
`endif
                end
                StStart: begin
                    if (r_div == BitLast) begin
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_out_bit;
                        r_buff  <= w_shifted;
                        r_state <= StData;
                    end else begin
                        r_div <= r_div + DivW'(1);
                    end
                end
                StData: begin
                    if (r_div == BitLast) begin
                        r_div <= '0;
                        if (r_bit == DataLast) begin
`ifdef CC_TX_PARITY_EN
                            r_tx    <= r_par;
                            r_state <= StParity;
`else
                            r_tx    <= 1'b1;
                            r_state <= StStop;
`endif
                        end else begin
                            r_bit  <= r_bit + BitW'(1);
                            r_tx   <= w_out_bit;
                            r_buff <= w_shifted;
                        end
                    end else begin
                        r_div <= r_div + DivW'(1);
                    end
                end
`ifdef CC_TX_PARITY_EN
                StParity: begin
                    if (r_div == BitLast) begin
                        r_div   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= StStop;
                    end else begin
                        r_div <= r_div + DivW'(1);
                    end
                end
`endif
                StStop: begin
                    if (r_div == StopLast) begin
                        r_div   <= '0;
                        r_words <= w_words_next;
                        if (w_words_next == FrameEnd) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            r_state <= StFetch;
                        end
                    end else begin
                        r_div <= r_div + DivW'(1);
                    end
                end
                StDone: begin
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rdaddress  = r_addr;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign words_sent = r_words;

endmodule
